// File: rtl/code_sequencer_pkg.sv
// Shared definitions for the code sequencer block.
//   state_t      : FSM state encoding (binary), ST_IDLE / ST_RUN
//   DIR_UP/DOWN  : values of the dir input
//   MODE_CONT/SINGLE : values of the mode input
package code_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler for the code sequencer.
// Counts 0..div_q while enabled; tick is high in the cycle the count sits
// at div_q, and the count wraps to 0 on that edge.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count to 0 (has priority over en)
//   load     : capture div as the new period limit
//   en       : advance the count
//   div      : step period minus 1, in clk cycles
//   tick     : period expired this cycle
module step_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] count;
    logic [PRESC_W-1:0] div_q;

    assign tick = en && !clear && (count == div_q);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the block samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            div_q <= '0;
        end else begin
            if (load)
                div_q <= div;
            if (clear)
                count <= '0;
            else if (en)
                count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/code_sequencer.sv
// Index sequencer feeding the 3-to-8 decoder's x_in bus.
// Produces 0..2^IDX_W-1 (up) or the reverse (down), one index per div+1
// clocks, in continuous (wrap) or single-sweep mode. All outputs are
// registered.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle pulse, begins a sequence from IDLE
//   stop     : one-cycle pulse, aborts a running sequence (beats start)
//   mode     : 0 continuous, 1 single sweep (latched at start)
//   dir      : 0 up, 1 down (live; applied at every step)
//   div      : step period minus 1 (latched at start)
//   x_out    : {1'b0, idx} to the decoder
//   x_valid  : x_out carries a live sequence value
//   step     : one-cycle pulse on each index change
//   busy     : sequencer is in RUN
//   done     : one-cycle pulse when a single sweep completes
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int PRESC_W = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [PRESC_W-1:0] div,
    output logic [IDX_W:0]     x_out,
    output logic               x_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             mode_q;
    logic             tick;
    logic             go;
    logic             at_terminal;
    logic [IDX_W-1:0] idx_next;

    // A start only counts from IDLE and only when no stop accompanies it.
    assign go = (state == ST_IDLE) && start && !stop;

    // Terminal index and next index both follow the live direction input.
    assign at_terminal = (dir == DIR_UP) ? (idx == IDX_MAX) : (idx == '0);
    assign idx_next    = (dir == DIR_UP) ? idx + 1'b1 : idx - 1'b1;

    assign x_out = {1'b0, idx};

    step_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear((state == ST_IDLE) || stop),
        .load (go),
        .en   (state == ST_RUN),
        .div  (div),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            mode_q  <= MODE_CONT;
            x_valid <= 1'b0;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised
            // only by the branch that wants them, so they never stick.
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state   <= ST_RUN;
                        idx     <= (dir == DIR_UP) ? '0 : IDX_MAX;
                        mode_q  <= mode;
                        busy    <= 1'b1;
                        x_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        x_valid <= 1'b0;
                    end else if (tick) begin
                        if (mode_q == MODE_SINGLE && at_terminal) begin
                            // Sweep complete: idx keeps its last value.
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            x_valid <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            idx  <= idx_next;
                            step <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer: a reset/continuous-up vector
// table, directed multi-cycle sequences, and randomized runs compared with
// an arithmetic reference model of the index sequence.
module tb_code_sequencer;
    import code_sequencer_pkg::*;

    localparam int PRESC_W = 8;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               mode;
    logic               dir;
    logic [PRESC_W-1:0] div;
    logic [IDX_W:0]     x_out;
    logic               x_valid;
    logic               step;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    code_sequencer #(
        .PRESC_W(PRESC_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .dir    (dir),
        .div    (div),
        .x_out  (x_out),
        .x_valid(x_valid),
        .step   (step),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [3:0] x;
        logic       v;
        logic       s;
        logic       b;
        logic       d;
    } outs_t;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic       dir;
        logic [7:0] div;
        outs_t      exp;
    } vec_t;

    function automatic outs_t observed();
        outs_t o;
        o.x = x_out;
        o.v = x_valid;
        o.s = step;
        o.b = busy;
        o.d = done;
        return o;
    endfunction

    function automatic outs_t mk_out(int x, bit v, bit s, bit b, bit d);
        outs_t o;
        o.x = 4'(x);
        o.v = v;
        o.s = s;
        o.b = b;
        o.d = d;
        return o;
    endfunction

    function automatic vec_t mk(bit st, bit sp, bit md, bit dr, int dv, outs_t e);
        vec_t v;
        v.start = st;
        v.stop  = sp;
        v.mode  = md;
        v.dir   = dr;
        v.div   = 8'(dv);
        v.exp   = e;
        return v;
    endfunction

    // Index shown during the k-th hold period of a sweep.
    function automatic int idx_of(int k, bit dr);
        return dr ? (7 - (k % 8)) : (k % 8);
    endfunction

    // Expected outputs t cycles after the start was sampled (t = 0 is the
    // first cycle with the start index showing). stop_at is the cycle in
    // which stop was driven (-1 = none).
    function automatic outs_t model(int t, int d, bit md, bit dr, int stop_at);
        int  p;
        int  len;
        bit  stopped;
        outs_t o;
        p       = d + 1;
        len     = 8 * p;
        stopped = (stop_at >= 0) && (stop_at < t) && (!md || stop_at < len);
        if (stopped)
            o = mk_out(idx_of(stop_at / p, dr), 0, 0, 0, 0);
        else if (md && t >= len)
            o = mk_out(idx_of(7, dr), 0, 0, 0, (t == len));
        else
            o = mk_out(idx_of(t / p, dr), 1, (t > 0 && (t % p) == 0), 1, 0);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit sp, input bit md, input bit dr, input int dv);
        start = st;
        stop  = sp;
        mode  = md;
        dir   = dr;
        div   = 8'(dv);
    endtask

    // Start a sequence and compare n cycles with the model. Mode and div
    // are scrambled during the run; they must have no effect.
    task automatic run_seq(input string name, input bit md, input bit dr, input int d,
                           input int n, input int stop_at, input int rep_at);
        int dones;
        int exp_dones;
        int len;
        len   = 8 * (d + 1);
        dones = 0;
        drive(1, 0, md, dr, d);
        tick();
        check($sformatf("%s t=0", name), observed(), model(0, d, md, dr, stop_at));
        if (done) dones++;
        for (int t = 1; t < n; t++) begin
            start = (t - 1 == rep_at);
            stop  = (t - 1 == stop_at);
            mode  = 1'($urandom);
            div   = 8'($urandom);
            tick();
            check($sformatf("%s t=%0d", name, t), observed(), model(t, d, md, dr, stop_at));
            if (done) dones++;
        end
        exp_dones = (md && n > len && !(stop_at >= 0 && stop_at < len)) ? 1 : 0;
        check($sformatf("%s done_count", name), dones, exp_dones);
        drive(0, 1, 0, 0, 0);
        tick();
        stop = 0;
        tick();
    endtask

    vec_t vecs[13];

    initial begin
        int found;
        int dones;

        // Continuous up, div 0, followed by stop and a start/stop collision.
        vecs[0] = mk(1, 0, 0, 0, 0, mk_out(0, 1, 0, 1, 0));
        for (int i = 1; i < 10; i++)
            vecs[i] = mk(0, 0, 0, 0, 0, mk_out(i % 8, 1, 1, 1, 0));
        vecs[10] = mk(0, 1, 0, 0, 0, mk_out(1, 0, 0, 0, 0));
        vecs[11] = mk(1, 1, 0, 0, 0, mk_out(1, 0, 0, 0, 0));
        vecs[12] = mk(0, 0, 0, 0, 0, mk_out(1, 0, 0, 0, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        check("reset_c1", observed(), mk_out(0, 0, 0, 0, 0));
        tick();
        check("reset_c2", observed(), mk_out(0, 0, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dir, int'(vecs[i].div));
            tick();
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end
        drive(0, 0, 0, 0, 0);

        // Directed sequences.
        run_seq("sweep_up_d4", 1, 0, 4, 43, -1, -1);
        run_seq("cont_down_d1", 0, 1, 1, 18, -1, -1);
        run_seq("sweep_down_d2", 1, 1, 2, 27, -1, -1);
        run_seq("restart_ignored", 0, 0, 3, 20, -1, 6);
        run_seq("stop_at_5", 0, 0, 2, 22, 16, -1);
        run_seq("stop_last_cycle", 1, 0, 1, 20, 15, -1);

        // Direction flip mid-run at idx 3 (continuous down, div 1).
        drive(1, 0, 0, 1, 1);
        tick();
        start = 0;
        for (int i = 0; i < 40 && !(x_out == 4'd3 && step); i++)
            tick();
        found = (x_out == 4'd3 && step) ? 1 : 0;
        check("flip_reach_3", found, 1);
        dir = 0;
        tick();
        check("flip_hold_3", observed(), mk_out(3, 1, 0, 1, 0));
        tick();
        check("flip_next_4", observed(), mk_out(4, 1, 1, 1, 0));
        drive(0, 1, 0, 0, 0);
        tick();
        stop = 0;

        // Reset during a single sweep at idx 6.
        drive(1, 0, 1, 0, 1);
        tick();
        start = 0;
        for (int i = 0; i < 40 && x_out != 4'd6; i++)
            tick();
        found = (x_out == 4'd6) ? 1 : 0;
        check("rst_reach_6", found, 1);
        rst = 1;
        tick();
        check("rst_mid_sweep", observed(), mk_out(0, 0, 0, 0, 0));
        rst = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("rst_no_done", dones, 0);
        check("rst_idle_after", observed(), mk_out(0, 0, 0, 0, 0));
        drive(1, 0, 0, 0, 2);
        tick();
        check("rst_restart", observed(), mk_out(0, 1, 0, 1, 0));
        drive(0, 1, 0, 0, 0);
        tick();
        stop = 0;
        tick();

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            bit md;
            bit dr;
            int d;
            int len;
            int n;
            int stop_at;
            int rep_at;
            int lim;
            md      = 1'($urandom);
            dr      = 1'($urandom);
            d       = int'($urandom_range(0, 4));
            len     = 8 * (d + 1);
            n       = len + int'($urandom_range(1, 4));
            stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            lim     = md ? len - 1 : n - 1;
            if (stop_at >= 0 && stop_at < lim)
                lim = stop_at;
            rep_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, lim)) : -1;
            run_seq($sformatf("rand%0d", r), md, dr, d, n, stop_at, rep_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
